// File: rtl/coin_pulse_gen_if.sv
// Coin front-end bus: raw buttons in, coin codes and status out.
// The master side drives the buttons; the slave side is the front end.
interface coin_pulse_gen_if;
    logic       btn_5;
    logic       btn_10;
    logic [1:0] coin_out;
    logic       coin_valid;
    logic       fifo_full;
    logic       drop_err;
    logic [7:0] coin_total;

    modport master (
        output btn_5,
        output btn_10,
        input  coin_out,
        input  coin_valid,
        input  fifo_full,
        input  drop_err,
        input  coin_total
    );

    modport slave (
        input  btn_5,
        input  btn_10,
        output coin_out,
        output coin_valid,
        output fifo_full,
        output drop_err,
        output coin_total
    );
endinterface

// File: rtl/coin_pulse_gen.sv
// Coin button front end: sync, debounce, edge detect, queue,
// and one registered coin code per press with idle spacing.
module coin_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int GAP_CYCLES      = 4
) (
    input logic             clk,
    input logic             reset,
    coin_pulse_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // bit 0 is the 5-unit button, bit 1 the 10-unit button
    logic [1:0]       w_btn;
    logic [1:0]       r_meta;
    logic [1:0]       r_sync;
    logic [1:0]       r_stable;
    logic [1:0]       r_stable_d;
    logic [1:0]       r_rise;
    logic [CNT_W-1:0] r_cnt [2];

    logic             r_pend_v;
    logic [1:0]       r_pend;
    logic             w_pend_v_nxt;
    logic [1:0]       w_pend_nxt;
    logic             w_wr;
    logic [1:0]       w_wr_data;
    logic             w_lost;

    logic [1:0]       r_mem [4];
    logic [1:0]       r_wptr;
    logic [1:0]       r_rptr;
    logic [2:0]       r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       w_code_nxt;
    logic             w_gap_load;
    logic             w_inc;
    logic [GW-1:0]    r_gap;
    logic [1:0]       r_coin;
    logic             r_valid;
    logic             r_drop;
    logic [7:0]       r_total;

    assign w_btn = {bus.btn_10, bus.btn_5};

    // two-flop synchroniser per button
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= w_btn;
            r_sync <= r_meta;
        end
    end

    // stable value flips only after a full run of differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= r_sync[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // registered press pulse on a 0->1 of the stable value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_d <= '0;
            r_rise     <= '0;
        end else begin
            r_stable_d <= r_stable;
            r_rise     <= r_stable & ~r_stable_d;
        end
    end

    // one write per cycle: pending first, then 5, then 10
    always_comb begin
        w_wr         = 1'b0;
        w_wr_data    = 2'b00;
        w_pend_v_nxt = r_pend_v;
        w_pend_nxt   = r_pend;
        w_lost       = 1'b0;
        if (r_pend_v) begin
            w_wr      = 1'b1;
            w_wr_data = r_pend;
            if (r_rise[0]) begin
                w_pend_nxt = 2'b01;
                w_lost     = r_rise[1];
            end else if (r_rise[1]) begin
                w_pend_nxt = 2'b10;
            end else begin
                w_pend_v_nxt = 1'b0;
            end
        end else if (r_rise[0]) begin
            w_wr      = 1'b1;
            w_wr_data = 2'b01;
            if (r_rise[1]) begin
                w_pend_v_nxt = 1'b1;
                w_pend_nxt   = 2'b10;
            end
        end else if (r_rise[1]) begin
            w_wr      = 1'b1;
            w_wr_data = 2'b10;
        end
    end

    // pending slot holds the 10 coin of a simultaneous press
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_v <= 1'b0;
            r_pend   <= 2'b00;
        end else begin
            r_pend_v <= w_pend_v_nxt;
            r_pend   <= w_pend_nxt;
        end
    end

    assign w_empty = (r_count == 3'd0);
    assign w_full  = (r_count == 3'd4);
    assign w_push  = w_wr & (~w_full | w_pop);
    assign w_ovf   = w_wr & w_full & ~w_pop;

    // event storage; a pop in the same cycle frees the full slot
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_wr_data;
        end
    end

    // fifo pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // sticky loss flag for overflow or pending collision
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= r_drop | w_ovf | w_lost;
        end
    end

    // output fsm state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // output fsm next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: w_state_nxt = S_GAP;
            S_GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // output fsm decode: pop, next code, gap load, total bump
    always_comb begin
        w_pop      = (r_state == S_IDLE) && !w_empty;
        w_code_nxt = w_pop ? r_mem[r_rptr] : 2'b00;
        w_gap_load = (r_state == S_EMIT);
        w_inc      = (r_state == S_EMIT) && (r_total != 8'hFF);
    end

    // registered code, valid, gap timer and saturating total
    always_ff @(posedge clk) begin
        if (reset) begin
            r_coin  <= 2'b00;
            r_valid <= 1'b0;
            r_gap   <= '0;
            r_total <= 8'd0;
        end else begin
            r_coin  <= w_code_nxt;
            r_valid <= |w_code_nxt;
            if (w_gap_load) begin
                r_gap <= GAP_LOAD;
            end else if (r_state == S_GAP && r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
            if (w_inc) begin
                r_total <= r_total + 8'd1;
            end
        end
    end

    assign bus.coin_out   = r_coin;
    assign bus.coin_valid = r_valid;
    assign bus.fifo_full  = w_full;
    assign bus.drop_err   = r_drop;
    assign bus.coin_total = r_total;

endmodule

// File: tb/tb_coin_pulse_gen.sv
// Bench for coin_pulse_gen: two instances (gap 2 and gap 20) share
// one stimulus; a queue-level model predicts every output cycle.
module tb_coin_pulse_gen;

    localparam int DB = 4;
    localparam int CW = 4;
    localparam int G0 = 2;
    localparam int G1 = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic b5    = 1'b0;
    logic b10   = 1'b0;
    logic s_b5  = 1'b0;
    logic s_b10 = 1'b0;
    logic s_rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    coin_pulse_gen_if cif0 ();
    coin_pulse_gen_if cif1 ();

    assign cif0.btn_5  = b5;
    assign cif0.btn_10 = b10;
    assign cif1.btn_5  = b5;
    assign cif1.btn_10 = b10;

    coin_pulse_gen #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CW),
        .GAP_CYCLES(G0)
    ) dut0 (
        .clk(clk),
        .reset(reset),
        .bus(cif0)
    );

    coin_pulse_gen #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(CW),
        .GAP_CYCLES(G1)
    ) dut1 (
        .clk(clk),
        .reset(reset),
        .bus(cif1)
    );

    always #5 clk = ~clk;

    // model state
    logic [31:0] sh5 = '0;
    logic [31:0] sh10 = '0;
    logic        st5 = 1'b0;
    logic        st10 = 1'b0;
    logic [1:0]  rq5 = '0;
    logic [1:0]  rq10 = '0;
    int          mq [2][$];
    int          stg [2][$];
    int          lg [2][$];
    int          lt [2][$];
    logic [1:0]  e_code [2];
    logic        e_full [2];
    logic        e_drop [2];
    logic [7:0]  e_tot [2];
    logic        emitted [2];
    int          next_ok [2];
    logic        seen_full [2];

    // inputs as the DUT saw them at the rising edge
    always @(posedge clk) begin
        s_b5  <= b5;
        s_b10 <= b10;
        s_rst <= reset;
    end

    function automatic int gap_of(input int k);
        return (k == 0) ? G0 : G1;
    endfunction

    function automatic int lgat(input int k, input int i);
        if (i < lg[k].size()) return lg[k][i];
        return -1;
    endfunction

    // model step for the edge just passed, then compare both DUTs
    always @(negedge clk) begin : chk
        logic f5, f10, r5, r10, a5, a10;
        logic [12:0] got, exp;
        int c;
        cyc = cyc + 1;
        if (s_rst) begin
            sh5  = '0;
            sh10 = '0;
            st5  = 1'b0;
            st10 = 1'b0;
            rq5  = '0;
            rq10 = '0;
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                stg[k].delete();
                e_code[k]  = 2'b00;
                e_full[k]  = 1'b0;
                e_drop[k]  = 1'b0;
                e_tot[k]   = 8'd0;
                emitted[k] = 1'b0;
                next_ok[k] = 0;
            end
        end else begin
            // presses that rose two edges ago reach the queue now
            a5  = rq5[1];
            a10 = rq10[1];
            // flip when the last DB synced samples all differ
            f5  = 1'b1;
            f10 = 1'b1;
            for (int j = 1; j <= DB; j++) begin
                if (sh5[j] == st5) f5 = 1'b0;
                if (sh10[j] == st10) f10 = 1'b0;
            end
            r5   = f5 & ~st5;
            r10  = f10 & ~st10;
            st5  = st5 ^ f5;
            st10 = st10 ^ f10;
            rq5  = {rq5[0], r5};
            rq10 = {rq10[0], r10};
            sh5  = {sh5[30:0], s_b5};
            sh10 = {sh10[30:0], s_b10};
            for (int k = 0; k < 2; k++) begin
                if (emitted[k] && e_tot[k] != 8'd255)
                    e_tot[k] = e_tot[k] + 8'd1;
                emitted[k] = 1'b0;
                e_code[k]  = 2'b00;
                if (mq[k].size() > 0 && cyc >= next_ok[k]) begin
                    e_code[k]  = 2'(mq[k].pop_front());
                    emitted[k] = 1'b1;
                    next_ok[k] = cyc + gap_of(k) + 2;
                end
                if (a5) stg[k].push_back(1);
                if (a10) stg[k].push_back(2);
                if (stg[k].size() > 0) begin
                    c = stg[k].pop_front();
                    if (mq[k].size() < 4) mq[k].push_back(c);
                    else e_drop[k] = 1'b1;
                end
                while (stg[k].size() > 1) begin
                    void'(stg[k].pop_back());
                    e_drop[k] = 1'b1;
                end
                e_full[k] = (mq[k].size() == 4);
            end
        end
        for (int k = 0; k < 2; k++) begin
            exp = {e_code[k], (e_code[k] != 2'b00), e_full[k],
                   e_drop[k], e_tot[k]};
            if (k == 0)
                got = {cif0.coin_out, cif0.coin_valid, cif0.fifo_full,
                       cif0.drop_err, cif0.coin_total};
            else
                got = {cif1.coin_out, cif1.coin_valid, cif1.fifo_full,
                       cif1.drop_err, cif1.coin_total};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL cycle_model dut%0d cyc %0d: got %h expected %h",
                         k, cyc, got, exp);
            end
            if (got[12:11] != 2'b00) begin
                lg[k].push_back(int'(got[12:11]));
                lt[k].push_back(cyc);
            end
            if (got[9]) seen_full[k] = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 2; k++) begin
            lg[k].delete();
            lt[k].delete();
            seen_full[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic alt_presses(input int n);
        for (int p = 0; p < n; p++) begin
            b5  = (p % 2 == 0);
            b10 = (p % 2 == 1);
            tick(7);
        end
        b5  = 1'b0;
        b10 = 1'b0;
    endtask

    initial begin
        int t0;
        int lat;
        logic [17:0] p2;
        seen_full[0] = 1'b0;
        seen_full[1] = 1'b0;

        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_coin", int'(cif0.coin_out), 0);
        check("rst_valid", int'(cif0.coin_valid), 0);
        check("rst_full", int'(cif0.fifo_full), 0);
        check("rst_total", int'(cif1.coin_total), 0);

        // single clean 5 press: exact latency, one-cycle code
        clear_logs();
        t0  = cyc;
        lat = -1;
        b5  = 1'b1;
        for (int i = 1; i <= 30 && lat < 0; i++) begin
            tick(1);
            if (i == 6) b5 = 1'b0;
            if (cif0.coin_out == 2'b01) lat = cyc - t0;
        end
        b5 = 1'b0;
        check("t1_latency", lat, DB + 5);
        check("t1_valid", int'(cif0.coin_valid), 1);
        tick(1);
        check("t1_one_cycle", int'(cif0.coin_out), 0);
        check("t1_total", int'(cif0.coin_total), 1);
        tick(60);
        check("t1_count", lg[0].size(), 1);

        // bouncy 10 press, then release
        clear_logs();
        p2 = 18'b110011001111111111;
        for (int i = 17; i >= 0; i--) begin
            b10 = p2[i];
            tick(1);
        end
        b10 = 1'b0;
        tick(60);
        check("t2_count", lg[0].size(), 1);
        check("t2_code", lgat(0, 0), 2);

        // simultaneous presses: 01 first, 10 four cycles later
        do_reset();
        clear_logs();
        b5  = 1'b1;
        b10 = 1'b1;
        tick(6);
        b5  = 1'b0;
        b10 = 1'b0;
        tick(70);
        check("t3_first", lgat(0, 0), 1);
        check("t3_second", lgat(0, 1), 2);
        check("t3_spacing",
              (lt[0].size() > 1) ? lt[0][1] - lt[0][0] : -1, G0 + 2);
        check("t3_total", int'(cif0.coin_total), 2);
        check("t3_g1_order", lgat(1, 1), 2);

        // overflow the gap-20 instance
        clear_logs();
        check("t4_drop_before", int'(cif1.drop_err), 0);
        alt_presses(7);
        tick(150);
        check("t4_full_seen", int'(seen_full[1]), 1);
        check("t4_drop", int'(cif1.drop_err), 1);
        check("t4_g0_nodrop", int'(cif0.drop_err), 0);
        check("t4_count", lg[1].size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t4_order%0d", i), lgat(1, i),
                  (i % 2 == 0) ? 1 : 2);
        end
        check("t4_g0_count", lg[0].size(), 7);

        // reset during gap with three queued
        alt_presses(5);
        tick(3);
        reset = 1'b1;
        tick(1);
        check("t5_coin", int'(cif1.coin_out), 0);
        check("t5_valid", int'(cif1.coin_valid), 0);
        check("t5_full", int'(cif1.fifo_full), 0);
        check("t5_drop", int'(cif1.drop_err), 0);
        check("t5_total", int'(cif1.coin_total), 0);
        reset = 1'b0;
        clear_logs();
        tick(80);
        check("t5_no_codes1", lg[1].size(), 0);
        check("t5_no_codes0", lg[0].size(), 0);

        // saturation of the coin total
        do_reset();
        clear_logs();
        for (int i = 0; i < 260; i++) begin
            b5 = 1'b1;
            tick(5);
            b5 = 1'b0;
            tick(5);
        end
        tick(30);
        check("t6_emitted", lg[0].size(), 260);
        check("t6_total", int'(cif0.coin_total), 255);
        check("t6_model_total", int'(e_tot[0]), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
